// File: rtl/rst_seq_gen.sv
// rst_seq_gen: staged reset sequencer for the PLL clock generator.
// Qualifies PLL lock, stretches reset, then releases domains in order.
module rst_seq_gen #(
    parameter int NUM_RST        = 4,
    parameter int STRETCH_CYCLES = 16,
    parameter int STAGE_GAP      = 8,
    parameter int LOCK_FILTER    = 4,
    parameter int CNT_W          = 8
) (
    input  logic               IO_CLK,
    input  logic               IO_RST_N,
    input  logic               pll_locked_i,
    input  logic               sw_rst_req_i,
    input  logic               lock_lost_clr_i,
    output logic [NUM_RST-1:0] rst_n_o,
    output logic               all_released_o,
    output logic               lock_lost_o,
    output logic [1:0]         state_o
);

    typedef enum logic [1:0] {
        WAIT_LOCK = 2'd0,
        STRETCH   = 2'd1,
        RELEASE   = 2'd2,
        RUN       = 2'd3
    } state_t;

    localparam logic [CNT_W-1:0] FILT_MAX     = CNT_W'(LOCK_FILTER);
    localparam logic [CNT_W-1:0] STRETCH_LAST = CNT_W'(STRETCH_CYCLES - 1);
    localparam logic [CNT_W-1:0] GAP_LAST     = CNT_W'(STAGE_GAP - 1);

    logic               sync_q;
    logic               locked_s;
    logic [CNT_W-1:0]   filt_q;
    logic               lock_ok;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [CNT_W-1:0]   cnt_last;
    logic [NUM_RST-1:0] rst_q, rst_d, rst_next;
    logic               all_q, all_d;
    logic               lost_q, lost_d;
    logic               lock_loss;
    logic               sw_go;

    always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
        if (!IO_RST_N) begin
            sync_q   <= 1'b0;
            locked_s <= 1'b0;
        end else begin
            sync_q   <= pll_locked_i;
            locked_s <= sync_q;
        end
    end

    // Saturating filter: any low synchronised sample restarts qualification.
    always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
        if (!IO_RST_N) begin
            filt_q <= '0;
        end else if (!locked_s) begin
            filt_q <= '0;
        end else if (filt_q != FILT_MAX) begin
            filt_q <= filt_q + CNT_W'(1);
        end
    end

    assign lock_ok   = (filt_q == FILT_MAX);
    assign lock_loss = !locked_s && (state_q != WAIT_LOCK);
    assign sw_go     = sw_rst_req_i && (state_q == RUN);
    assign rst_next  = (rst_q << 1) | NUM_RST'(1);
    assign cnt_last  = (state_q == STRETCH) ? STRETCH_LAST : GAP_LAST;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        rst_d   = rst_q;
        all_d   = all_q;
        if (lock_loss) begin
            state_d = WAIT_LOCK;
            cnt_d   = '0;
            rst_d   = '0;
            all_d   = 1'b0;
        end else if (sw_go) begin
            state_d = STRETCH;
            cnt_d   = '0;
            rst_d   = '0;
            all_d   = 1'b0;
        end else begin
            unique case (state_q)
                WAIT_LOCK: begin
                    rst_d = '0;
                    all_d = 1'b0;
                    if (lock_ok) begin
                        state_d = STRETCH;
                        cnt_d   = '0;
                    end
                end
                STRETCH, RELEASE: begin
                    if (cnt_q == cnt_last) begin
                        // Shifting a one in keeps release strictly in order.
                        rst_d   = rst_next;
                        cnt_d   = '0;
                        all_d   = &rst_next;
                        state_d = (&rst_next) ? RUN : RELEASE;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                RUN: begin
                    rst_d = '1;
                    all_d = 1'b1;
                end
                default: begin
                    state_d = WAIT_LOCK;
                end
            endcase
        end
    end

    // Set beats clear so a simultaneous clear cannot hide a lock loss.
    always_comb begin
        lost_d = lost_q;
        if (lock_loss) begin
            lost_d = 1'b1;
        end else if (lock_lost_clr_i) begin
            lost_d = 1'b0;
        end
    end

    always_ff @(posedge IO_CLK or negedge IO_RST_N) begin
        if (!IO_RST_N) begin
            state_q <= WAIT_LOCK;
            cnt_q   <= '0;
            rst_q   <= '0;
            all_q   <= 1'b0;
            lost_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rst_q   <= rst_d;
            all_q   <= all_d;
            lost_q  <= lost_d;
        end
    end

    assign rst_n_o        = rst_q;
    assign all_released_o = all_q;
    assign lock_lost_o    = lost_q;
    assign state_o        = state_q;

endmodule

// File: doc/rst_seq_gen.md
Name: rst_seq_gen

Overview:
Parametrised reset sequencer that replaces the simple `locked & IO_RST_N` reset gating used with the 7-series PLL clock generator.
- Synchronises and filters the PLL lock indication.
- Stretches reset for a programmable time after lock is qualified.
- Releases NUM_RST reset domains one at a time, in order, with a programmable gap between them.
- Re-asserts all domains on loss of lock or on a software reset request.
- Reports sequencer state and a sticky lock-loss flag.

Parameters:
NUM_RST, 4, number of reset outputs; released in order 0..NUM_RST-1 (1..16).
STRETCH_CYCLES, 16, cycles spent in STRETCH before rst_n_o[0] is released (>=1).
STAGE_GAP, 8, cycles between release of rst_n_o[k-1] and rst_n_o[k] (>=1).
LOCK_FILTER, 4, consecutive synchronised-lock-high cycles needed to qualify lock (>=1).
CNT_W, 8, width of the internal stretch/gap/filter counters; must hold max(STRETCH_CYCLES, STAGE_GAP, LOCK_FILTER).

Ports:
IO_CLK  in  1  clock; all logic is on its rising edge.
IO_RST_N  in  1  asynchronous active-low reset.
pll_locked_i  in  1  PLL LOCKED; asynchronous to IO_CLK, synchronised internally.
sw_rst_req_i  in  1  synchronous single-cycle software reset request.
lock_lost_clr_i  in  1  synchronous clear for lock_lost_o.
rst_n_o  out  NUM_RST  active-low domain resets; registered.
all_released_o  out  1  high while every rst_n_o bit is high.
lock_lost_o  out  1  sticky flag: qualified lock was lost.
state_o  out  2  0=WAIT_LOCK, 1=STRETCH, 2=RELEASE, 3=RUN.

Behaviour:
- Reset (IO_RST_N low, asynchronous), all outputs and flops cleared:
  - rst_n_o = 0, all_released_o = 0, lock_lost_o = 0, state_o = WAIT_LOCK.
  - Both sync flops, the filter counter and the sequence counters = 0.
- Reset asserted mid-sequence clears everything immediately; the sequence restarts from WAIT_LOCK after deassertion.
- Lock synchroniser:
  - Two-flop synchroniser: pll_locked_i -> locked_s, 2-cycle latency.
  - Filter counter increments while locked_s=1, saturating at LOCK_FILTER; it clears on any cycle with locked_s=0.
  - lock_ok = (filter counter == LOCK_FILTER).
- WAIT_LOCK:
  - rst_n_o all 0.
  - On the first cycle with lock_ok=1, the next edge enters STRETCH and clears the sequence counter.
- STRETCH:
  - rst_n_o all 0; the counter increments every cycle.
  - The edge STRETCH_CYCLES cycles after entry moves to RELEASE and sets rst_n_o[0]=1 on that same edge.
- RELEASE:
  - Each further STAGE_GAP cycles, the next rst_n_o bit is set; bits are never released out of order.
  - The edge that sets rst_n_o[NUM_RST-1] also moves to RUN and sets all_released_o=1.
  - With NUM_RST=1, STRETCH goes directly to RUN (RELEASE is skipped) and all_released_o rises with rst_n_o[0].
- RUN: all rst_n_o = 1; hold.
- Loss of lock:
  - Trigger: locked_s=0 in any state other than WAIT_LOCK.
  - Next edge: state = WAIT_LOCK, rst_n_o all 0, all_released_o = 0, lock_lost_o = 1.
  - Lock must then re-qualify through the filter.
- Software reset:
  - sw_rst_req_i=1 in RUN with locked_s=1: next edge gives rst_n_o all 0, all_released_o = 0, state = STRETCH, counter cleared. No lock wait.
  - sw_rst_req_i is ignored in WAIT_LOCK, STRETCH and RELEASE.
- Priority, highest first: IO_RST_N > lock loss > sw_rst_req_i > normal sequencing.
- lock_lost_o:
  - Set by lock loss; cleared by lock_lost_clr_i.
  - Set wins when set and clear occur in the same cycle.
  - A lock glitch during WAIT_LOCK does not set the flag.
- Counters never wrap: each counter is cleared on every state change and only compared for equality.

Test Plan:
- Defaults; release IO_RST_N, raise pll_locked_i and hold -> state_o WAIT_LOCK->STRETCH after synchroniser + 4 filter cycles; rst_n_o[0] rises exactly 16 cycles after STRETCH entry; bits 1,2,3 rise at +8, +16, +24; all_released_o and state_o=3 on the same edge as bit 3.
- pll_locked_i high for 3 cycles then low, repeated 10 times -> state_o stays 0, rst_n_o=4'b0000, lock_lost_o=0.
- In RUN, drop pll_locked_i for 1 cycle -> 2 cycles later rst_n_o=0, state_o=0, lock_lost_o=1. On re-lock, the full sequence repeats and lock_lost_o stays 1 until lock_lost_clr_i is pulsed.
- In RUN, pulse sw_rst_req_i -> next edge rst_n_o=0, state_o=1; release timing identical to the first scenario from STRETCH entry. A pulse during RELEASE (rst_n_o=4'b0011) has no effect.
- Lock loss in RUN in the same cycle as sw_rst_req_i and lock_lost_clr_i -> state_o=0 (not 1), lock_lost_o=1.
- IO_RST_N pulsed low while in RELEASE -> all outputs 0 asynchronously. After release with lock held, the sequence restarts from WAIT_LOCK. Repeat with NUM_RST=1 and STAGE_GAP=1 -> rst_n_o[0] and all_released_o rise together.
